// File: rtl/regwb_pkg.sv
// Shared widths and the queued writeback entry record for the register writeback unit.
// Pure type/constant package; no logic, no latency.
package regwb_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = $clog2(NUM_REGS);

  typedef struct packed {
    logic [REG_AW-1:0] rnum;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regwb_fifo.sv
// Circular queue of writeback entries; push lands at the edge and is visible as head next cycle.
// Refuses push when full and pop when empty; the full contents are exposed for forwarding lookup.
module regwb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  wb_entry_t              push_entry_i,
  input  logic                   pop_i,
  output wb_entry_t              head_o,
  output logic                   full_o,
  output logic [CNT_W-1:0]       count_o,
  output logic [PTR_W-1:0]       rd_ptr_o,
  output wb_entry_t [DEPTH-1:0]  entries_o
);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  wb_entry_t [DEPTH-1:0] mem_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (count_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/reg_writeback_unit.sv
// Arbitrates load/ALU results into a writeback queue and drains it to the register-file port.
// One cycle queue-to-port latency; ready drops when full, stall holds the port; forwarding is combinational.
module reg_writeback_unit
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_valid,
  input  logic [2:0]                   ld_reg,
  input  logic [7:0]                   ld_data,
  output logic                         ld_ready,
  input  logic                         alu_valid,
  input  logic [2:0]                   alu_reg,
  input  logic [7:0]                   alu_data,
  output logic                         alu_ready,
  input  logic                         stall,
  output logic                         wr_en,
  output logic [2:0]                   wr_reg,
  output logic [7:0]                   wr_data,
  input  logic [2:0]                   chk_reg_1,
  input  logic [2:0]                   chk_reg_2,
  output logic                         hit_1,
  output logic                         hit_2,
  output logic [7:0]                   fwd_data_1,
  output logic [7:0]                   fwd_data_2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t             push_entry;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      q_count;
  logic                  full, push, pop;

  logic                  wr_en_q, wr_en_d;
  logic [REG_AW-1:0]     wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;

  // Load wins a tie; full is judged on the current count, so a same-edge pop frees nothing.
  assign ld_ready  = !full;
  assign alu_ready = !full && !ld_valid;
  assign push      = (ld_valid && ld_ready) || (alu_valid && alu_ready);
  assign pop       = (q_count != '0) && !stall;

  always_comb begin
    push_entry = '0;
    if (ld_valid) begin
      push_entry.rnum = ld_reg;
      push_entry.data = ld_data;
    end else begin
      push_entry.rnum = alu_reg;
      push_entry.data = alu_data;
    end
  end

  regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (full),
    .count_o      (q_count),
    .rd_ptr_o     (rd_ptr),
    .entries_o    (entries)
  );

  always_comb begin
    wr_en_d   = pop;
    wr_reg_d  = pop ? head.rnum : wr_reg_q;
    wr_data_d = pop ? head.data : wr_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Scan oldest to youngest so the last queued match wins over the presented entry.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [REG_AW-1:0] r);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    idx = '0;
    if (wr_en_q && (wr_reg_q == r)) res = {1'b1, wr_data_q};
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((i < int'(q_count)) && (entries[idx].rnum == r)) res = {1'b1, entries[idx].data};
    end
    return res;
  endfunction

  always_comb begin
    {hit_1, fwd_data_1} = fwd_lookup(chk_reg_1);
    {hit_2, fwd_data_2} = fwd_lookup(chk_reg_2);
  end

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;
  assign count   = q_count;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit: arbitration, ordering, backpressure, forwarding, reset.
module tb_reg_writeback_unit;

  logic       clk, rst;
  logic       ld_valid, alu_valid, stall;
  logic [2:0] ld_reg, alu_reg, chk_reg_1, chk_reg_2, wr_reg;
  logic [7:0] ld_data, alu_data, wr_data, fwd_data_1, fwd_data_2;
  logic       ld_ready, alu_ready, wr_en, hit_1, hit_2;
  logic [2:0] count;

  int checks   = 0;
  int failures = 0;

  reg_writeback_unit #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_reg     (ld_reg),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .alu_valid  (alu_valid),
    .alu_reg    (alu_reg),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .stall      (stall),
    .wr_en      (wr_en),
    .wr_reg     (wr_reg),
    .wr_data    (wr_data),
    .chk_reg_1  (chk_reg_1),
    .chk_reg_2  (chk_reg_2),
    .hit_1      (hit_1),
    .hit_2      (hit_2),
    .fwd_data_1 (fwd_data_1),
    .fwd_data_2 (fwd_data_2),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ld(input logic [2:0] r, input logic [7:0] d);
    ld_valid = 1'b1;
    ld_reg   = r;
    ld_data  = d;
    step();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    ld_valid = 1'b0; ld_reg = '0; ld_data = '0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    chk_reg_1 = '0; chk_reg_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_count", count, 0);
    check("rst_wr_reg", wr_reg, 0);
    check("rst_wr_data", wr_data, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ld_rdy", ld_ready, 1);
    check("post_rst_alu_rdy", alu_ready, 1);
    check("post_rst_hit1", hit_1, 0);
    check("post_rst_fwd1", fwd_data_1, 0);
    check("post_rst_hit2", hit_2, 0);

    // single load, two-cycle latency to the write port
    ld_valid = 1'b1; ld_reg = 3'd3; ld_data = 8'hA5;
    #1;
    check("ld_hi_alu_rdy", alu_ready, 0);
    step();
    ld_valid = 1'b0; chk_reg_1 = 3'd3;
    #1;
    check("lat_cnt1", count, 1);
    check("lat_wr_en_early", wr_en, 0);
    check("lat_hit_q", hit_1, 1);
    check("lat_fwd_q", fwd_data_1, 8'hA5);
    step();
    check("lat_wr_en", wr_en, 1);
    check("lat_wr_reg", wr_reg, 3);
    check("lat_wr_data", wr_data, 8'hA5);
    check("lat_cnt0", count, 0);
    check("lat_hit_wr", hit_1, 1);
    step();
    check("lat_wr_en_drop", wr_en, 0);
    check("lat_wr_reg_hold", wr_reg, 3);
    check("lat_hit_gone", hit_1, 0);

    // tie: load wins, alu goes next cycle
    ld_valid = 1'b1; ld_reg = 3'd1; ld_data = 8'h11;
    alu_valid = 1'b1; alu_reg = 3'd2; alu_data = 8'h22;
    #1;
    check("tie_ld_rdy", ld_ready, 1);
    check("tie_alu_rdy", alu_ready, 0);
    step();
    ld_valid = 1'b0;
    #1;
    check("tie_alu_rdy2", alu_ready, 1);
    check("tie_cnt", count, 1);
    step();
    alu_valid = 1'b0;
    check("tie_w1_en", wr_en, 1);
    check("tie_w1_reg", wr_reg, 1);
    check("tie_w1_dat", wr_data, 8'h11);
    check("tie_cnt_same", count, 1);
    step();
    check("tie_w2_reg", wr_reg, 2);
    check("tie_w2_dat", wr_data, 8'h22);
    check("tie_cnt0", count, 0);
    step();
    check("tie_idle", wr_en, 0);

    // fill under stall, refuse fifth even across a pop, drain in order
    stall = 1'b1;
    push_ld(3'd4, 8'h41);
    push_ld(3'd5, 8'h52);
    push_ld(3'd6, 8'h63);
    push_ld(3'd7, 8'h74);
    ld_reg = 3'd0; ld_data = 8'h99;
    #1;
    check("full_cnt", count, 4);
    check("full_ld_rdy", ld_ready, 0);
    check("full_alu_rdy", alu_ready, 0);
    check("full_no_wr", wr_en, 0);
    step();
    check("full_refuse_cnt", count, 4);
    stall = 1'b0;
    step();
    ld_valid = 1'b0;
    check("drain0_en", wr_en, 1);
    check("drain0_reg", wr_reg, 4);
    check("drain0_dat", wr_data, 8'h41);
    check("drain0_cnt", count, 3);
    step();
    check("drain1_en", wr_en, 1);
    check("drain1_reg", wr_reg, 5);
    check("drain1_dat", wr_data, 8'h52);
    check("drain1_cnt", count, 2);
    step();
    check("drain2_en", wr_en, 1);
    check("drain2_reg", wr_reg, 6);
    check("drain2_dat", wr_data, 8'h63);
    step();
    check("drain3_en", wr_en, 1);
    check("drain3_reg", wr_reg, 7);
    check("drain3_dat", wr_data, 8'h74);
    check("drain3_cnt", count, 0);
    step();
    check("drain_end_en", wr_en, 0);

    // forwarding: youngest queued wins, then presented entry; r0 is ordinary
    stall = 1'b1;
    push_ld(3'd5, 8'h10);
    push_ld(3'd5, 8'h20);
    ld_valid = 1'b0; chk_reg_1 = 3'd5; chk_reg_2 = 3'd6;
    #1;
    check("fwd_hit1", hit_1, 1);
    check("fwd_dat1", fwd_data_1, 8'h20);
    check("fwd_hit2_miss", hit_2, 0);
    check("fwd_dat2_miss", fwd_data_2, 0);
    push_ld(3'd0, 8'h5A);
    ld_valid = 1'b0; chk_reg_2 = 3'd0;
    #1;
    check("fwd_r0_hit", hit_2, 1);
    check("fwd_r0_dat", fwd_data_2, 8'h5A);
    check("fwd_cnt3", count, 3);
    stall = 1'b0;
    step();
    check("fwd_wr_old", wr_data, 8'h10);
    check("fwd_q_over_wr", fwd_data_1, 8'h20);
    step();
    check("fwd_wr_new", wr_data, 8'h20);
    check("fwd_from_wr_hit", hit_1, 1);
    check("fwd_from_wr_dat", fwd_data_1, 8'h20);
    step();
    check("fwd_r0_wr_reg", wr_reg, 0);
    check("fwd_r0_wr_dat", wr_data, 8'h5A);
    check("fwd_r0_wr_en", wr_en, 1);
    check("fwd_r5_gone", hit_1, 0);
    check("fwd_r5_gone_dat", fwd_data_1, 0);
    step();
    check("fwd_idle", wr_en, 0);

    // reset mid-operation discards queued and presented entries
    stall = 1'b1;
    push_ld(3'd1, 8'hA1);
    push_ld(3'd2, 8'hA2);
    push_ld(3'd3, 8'hA3);
    push_ld(3'd4, 8'hA4);
    ld_valid = 1'b0; stall = 1'b0;
    step();
    stall = 1'b1; chk_reg_1 = 3'd2;
    check("mid_cnt3", count, 3);
    check("mid_wr_en", wr_en, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_cnt", count, 0);
    check("mid_rst_wr_reg", wr_reg, 0);
    check("mid_rst_wr_dat", wr_data, 0);
    check("mid_rst_hit", hit_1, 0);
    step();
    rst = 1'b0; stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_mid_wr_en", wr_en, 0);
      check("post_mid_cnt", count, 0);
    end
    check("post_mid_ld_rdy", ld_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
